// File: rtl/pkg_seq.sv
// Shared definitions for the instruction sequencer.
//   seq_state_t : sequencer FSM state encoding
//   INSTR_BYTES : byte stride between consecutive instructions
package pkg_seq;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } seq_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acknowledged fetch cycles and flags the cycle in
// which the LIMIT-th such cycle occurs.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the count
//   clear   : restart the count (asserted on entry to FETCH)
//   tick    : one more fetch cycle without ack
//   expired : this tick is the LIMIT-th consecutive one
module fetch_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [7:0] cnt;

    // Combinational so the sequencer can leave FETCH at the end of the
    // LIMIT-th cycle rather than one cycle later.
    assign expired = tick && (cnt == 8'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch / decode / execute sequencer for a simple in-order core.
//   clk, rst               : clock, synchronous active-high reset
//   run                    : start request (IDLE only)
//   fetch_req/addr/ack/data: instruction RAM handshake
//   ir, dec_en             : instruction register and decoder enable
//   exec_start, exec_done  : execute strobe / completion from the units
//   halt, jmp_valid/target : execution outcome, valid with exec_done
//   pc, instret            : program counter, retired-instruction count
//   halted, fault          : terminal state indicators
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | fetch_req high, waiting for fetch_ack or timeout
// DECODE | one-cycle decoder enable on the new ir
// EXEC   | exec_start on the first cycle, wait for exec_done
// HALTED | halt retired; left only by rst
// FAULT  | fetch timeout or misaligned jump; left only by rst
module instr_sequencer
    import pkg_seq::*;
#(
    parameter int          FETCH_TIMEOUT = 255,
    parameter logic [63:0] PC_RESET      = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        fetch_req,
    output logic [63:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] ir,
    output logic        dec_en,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        halt,
    input  logic        jmp_valid,
    input  logic [63:0] jmp_target,
    output logic [63:0] pc,
    output logic [63:0] instret,
    output logic        halted,
    output logic        fault
);

    seq_state_t  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] ir_q, ir_d;
    logic        exec_first;
    logic        wd_clear, wd_tick, wd_expired;

    // Kept outside the FSM process so the watchdog's combinational
    // expired output does not close a loop through that process.
    assign wd_tick  = (state_q == FETCH) && !fetch_ack;
    assign wd_clear = (state_d == FETCH) && (state_q != FETCH);

    fetch_watchdog #(.LIMIT(FETCH_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            instret_q  <= '0;
            ir_q       <= '0;
            exec_first <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            ir_q       <= ir_d;
            // EXEC is only ever entered from DECODE.
            exec_first <= (state_q == DECODE);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        ir_d      = ir_q;
        fetch_req = 1'b0;
        dec_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    ir_d    = fetch_data;
                    state_d = DECODE;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                dec_en  = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        instret_d = instret_q + 64'd1;
                        state_d   = HALTED;
                    end else if (jmp_valid) begin
                        if (jmp_target[1:0] == 2'b00) begin
                            pc_d      = jmp_target;
                            instret_d = instret_q + 64'd1;
                            state_d   = FETCH;
                        end else begin
                            state_d = FAULT;
                        end
                    end else begin
                        pc_d      = pc_q + 64'(INSTR_BYTES);
                        instret_d = instret_q + 64'd1;
                        state_d   = FETCH;
                    end
                end
            end
            HALTED: state_d = HALTED;
            FAULT:  state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign exec_start = (state_q == EXEC) && exec_first;
    assign fetch_addr = pc_q;
    assign pc         = pc_q;
    assign instret    = instret_q;
    assign ir         = ir_q;
    assign halted     = (state_q == HALTED);
    assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, fetch_ack, exec_done, halt, jmp_valid;
    logic [31:0] fetch_data;
    logic [63:0] jmp_target;
    logic        fetch_req, dec_en, exec_start, halted, fault;
    logic [63:0] fetch_addr, pc, instret;
    logic [31:0] ir;

    int errors = 0;
    int checks = 0;

    logic [63:0] m_pc, m_instret;
    logic [31:0] ir_sb[$];
    logic [63:0] pc_sb[$];
    logic [63:0] ins_sb[$];

    instr_sequencer #(.FETCH_TIMEOUT(3), .PC_RESET(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .ir         (ir),
        .dec_en     (dec_en),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .halt       (halt),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .pc         (pc),
        .instret    (instret),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 0; fetch_ack = 0; exec_done = 0; halt = 0;
        jmp_valid = 0; jmp_target = '0; fetch_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        m_pc = 64'h0;
        m_instret = 64'h0;
    endtask

    task automatic start_run();
        run = 1;
        tick();
        run = 0;
    endtask

    // Precondition: DUT observed in its first FETCH cycle.
    // outcome: 0 back to FETCH, 1 HALTED, 2 FAULT.
    task automatic run_instr(input logic [31:0] data, input int ack_wait, input int exec_wait,
                             input logic h, input logic jv, input logic [63:0] tgt);
        int outcome;
        logic [63:0] exp_pc, exp_ins;
        for (int i = 0; i < ack_wait; i++) begin
            check("fetch_wait_req", fetch_req, 1);
            check("fetch_wait_fault", fault, 0);
            tick();
        end
        check("fetch_req", fetch_req, 1);
        check("fetch_addr", fetch_addr, m_pc);
        fetch_ack = 1;
        fetch_data = data;
        ir_sb.push_back(data);
        tick();
        fetch_ack = 0;
        fetch_data = '0;
        check("decode_dec_en", dec_en, 1);
        check("decode_fetch_req", fetch_req, 0);
        check("decode_exec_start", exec_start, 0);
        if (ir_sb.size() == 0) check("ir_sb_empty", 1, 0);
        else check("ir", ir, ir_sb.pop_front());
        tick();
        check("exec_start", exec_start, 1);
        check("exec_dec_en", dec_en, 0);
        for (int i = 0; i < exec_wait; i++) begin
            tick();
            check("exec_start_once", exec_start, 0);
        end
        exec_done = 1; halt = h; jmp_valid = jv; jmp_target = tgt;
        if (h) begin
            m_instret = m_instret + 64'd1;
            outcome = 1;
        end else if (jv && tgt[1:0] != 2'b00) begin
            outcome = 2;
        end else begin
            m_pc = jv ? tgt : m_pc + 64'd4;
            m_instret = m_instret + 64'd1;
            outcome = 0;
        end
        pc_sb.push_back(m_pc);
        ins_sb.push_back(m_instret);
        tick();
        idle_inputs();
        if (pc_sb.size() == 0) check("pc_sb_empty", 1, 0);
        else begin
            exp_pc = pc_sb.pop_front();
            exp_ins = ins_sb.pop_front();
            check("retire_pc", pc, exp_pc);
            check("retire_instret", instret, exp_ins);
        end
        check("retire_halted", halted, (outcome == 1) ? 1 : 0);
        check("retire_fault", fault, (outcome == 2) ? 1 : 0);
        check("retire_fetch_req", fetch_req, (outcome == 0) ? 1 : 0);
        if (outcome == 0) check("next_fetch_addr", fetch_addr, m_pc);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();

        // Reset state
        do_reset();
        check("rst_fetch_req", fetch_req, 0);
        check("rst_dec_en", dec_en, 0);
        check("rst_exec_start", exec_start, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_pc", pc, 64'h0);
        check("rst_instret", instret, 64'h0);
        check("rst_ir", ir, 0);

        // Inputs other than run ignored in IDLE
        fetch_ack = 1; exec_done = 1; jmp_valid = 1; jmp_target = 64'h40;
        tick(); tick();
        idle_inputs();
        check("idle_no_fetch", fetch_req, 0);
        check("idle_pc", pc, 64'h0);

        // Basic instruction, exec_done with the start strobe
        start_run();
        run_instr(32'h1200_0001, 0, 0, 0, 0, 64'h0);
        // Aligned jump with multi-cycle exec
        run_instr(32'hA5A5_0002, 0, 2, 0, 1, 64'h100);
        // Ack on second fetch cycle
        run_instr(32'h0000_0003, 1, 0, 0, 0, 64'h0);
        // Ack on the timeout cycle wins, then misaligned jump faults
        run_instr(32'hDEAD_BEEF, 2, 1, 0, 1, 64'h102);
        run = 1;
        tick(); tick();
        run = 0;
        check("fault_sticky", fault, 1);
        check("fault_no_fetch", fetch_req, 0);
        check("fault_pc_hold", pc, 64'h104);

        // Reset in the middle of EXEC at pc=8
        do_reset();
        start_run();
        run_instr(32'h1111_0000, 0, 0, 0, 0, 64'h0);
        run_instr(32'h2222_0000, 0, 0, 0, 0, 64'h0);
        check("pre_rst_pc", pc, 64'h8);
        fetch_ack = 1; fetch_data = 32'h3333_0000;
        tick();
        fetch_ack = 0;
        tick();
        check("mid_exec_start", exec_start, 1);
        rst = 1; exec_done = 1; jmp_valid = 1; jmp_target = 64'h300; run = 1;
        tick();
        rst = 0;
        idle_inputs();
        m_pc = 64'h0; m_instret = 64'h0;
        check("exec_rst_pc", pc, 64'h0);
        check("exec_rst_instret", instret, 64'h0);
        check("exec_rst_ir", ir, 0);
        check("exec_rst_strobes", {fetch_req, dec_en, exec_start, halted, fault}, 0);
        tick(); tick(); tick();
        check("exec_rst_no_fetch", fetch_req, 0);

        // Fetch timeout: fault after exactly 3 un-acked FETCH cycles
        start_run();
        for (int i = 0; i < 3; i++) begin
            check("to_fetch_req", fetch_req, 1);
            check("to_no_fault_yet", fault, 0);
            tick();
        end
        check("to_fault", fault, 1);
        check("to_fetch_req_low", fetch_req, 0);
        check("to_pc", pc, 64'h0);
        fetch_ack = 1;
        tick();
        fetch_ack = 0;
        check("to_ack_ignored", dec_en, 0);

        // halt overrides jmp_valid
        do_reset();
        start_run();
        run_instr(32'h0000_F00F, 0, 0, 1, 1, 64'h200);
        check("halt_pc_hold", pc, 64'h0);
        run = 1; fetch_ack = 1;
        tick(); tick();
        idle_inputs();
        check("halt_sticky", halted, 1);
        check("halt_no_fetch", fetch_req, 0);
        check("halt_instret", instret, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
